// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared state type, default geometry and beat-slice helper for the line-burst sequencer
package mem_seq_pkg;

  localparam int MEM_DWIDTH_DEF = 32;
  localparam int BEATS_DEF      = 8;
  localparam int LAWIDTH_DEF    = 23;
  localparam int BEAT_W         = $clog2(BEATS_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_RESP
  } state_e;

  // Bit offset of beat `beat` in a line-wide vector built from `width`-bit slices.
  function automatic int beat_lsb(input int beat, input int width);
    return beat * width;
  endfunction

endpackage

// File: rtl/mem_burst_seq_line_buffer.sv
// rtl/mem_burst_seq_line_buffer.sv - beat-indexed word store with full-line read-out
module mem_line_buffer #(
  parameter int DW    = 32,
  parameter int BEATS = 8,
  parameter int BW    = $clog2(BEATS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [BW-1:0]       wr_idx_i,
  input  logic [DW-1:0]       wr_data_i,
  output logic [DW*BEATS-1:0] line_o
);

  logic [DW-1:0] words_q [BEATS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < BEATS; b++) begin
        words_q[b] <= '0;
      end
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line_o[g*DW +: DW] = words_q[g];
  end

endmodule

// File: rtl/mem_burst_seq.sv
// rtl/mem_burst_seq.sv - splits line read/write requests into word beats for a 1-cycle-latency memory
module mem_burst_seq
  import mem_seq_pkg::*;
#(
  parameter int MEM_DWIDTH = MEM_DWIDTH_DEF,
  parameter int BEATS      = BEATS_DEF,
  parameter int LAWIDTH    = LAWIDTH_DEF,
  parameter int AWIDTH     = LAWIDTH + $clog2(BEATS),
  parameter int LWIDTH     = MEM_DWIDTH * BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [LAWIDTH-1:0]      req_addr,
  input  logic [LWIDTH-1:0]       req_wdata,
  input  logic [LWIDTH/8-1:0]     req_byteen,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [LWIDTH-1:0]       rsp_rdata,
  output logic [AWIDTH-1:0]       mem_address,
  output logic                    mem_wren,
  output logic [MEM_DWIDTH-1:0]   mem_data,
  output logic [MEM_DWIDTH/8-1:0] mem_byteen,
  input  logic [MEM_DWIDTH-1:0]   mem_out
);

  localparam int BW = $clog2(BEATS);
  localparam int MB = MEM_DWIDTH / 8;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_e                  state_q;
  logic                    req_ready_q, rsp_valid_q, rsp_we_q;
  logic [LAWIDTH-1:0]      addr_q;
  logic [LWIDTH-1:0]       wdata_q;
  logic [LWIDTH/8-1:0]     byteen_q;
  logic [BW-1:0]           beat_q;
  logic [AWIDTH-1:0]       mem_address_q;
  logic                    mem_wren_q;
  logic [MEM_DWIDTH-1:0]   mem_data_q;
  logic [MB-1:0]           mem_byteen_q;
  // Read capture pipeline: issued beat -> data on mem_out -> buffer write.
  logic                    rd_vld_q, cap_vld_q;
  logic [BW-1:0]           rd_idx_q, cap_idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_we_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      byteen_q      <= '0;
      beat_q        <= '0;
      mem_address_q <= '0;
      mem_wren_q    <= 1'b0;
      mem_data_q    <= '0;
      mem_byteen_q  <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      cap_vld_q     <= 1'b0;
      cap_idx_q     <= '0;
    end else begin
      cap_vld_q    <= rd_vld_q;
      cap_idx_q    <= rd_idx_q;
      rd_vld_q     <= 1'b0;
      mem_wren_q   <= 1'b0;
      mem_byteen_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            rsp_we_q    <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            byteen_q    <= req_byteen;
            beat_q      <= '0;
            state_q     <= req_we ? S_WR : S_RD;
          end
        end
        S_WR: begin
          mem_address_q <= {addr_q, beat_q};
          mem_wren_q    <= 1'b1;
          mem_data_q    <= wdata_q[beat_lsb(int'(beat_q), MEM_DWIDTH) +: MEM_DWIDTH];
          mem_byteen_q  <= byteen_q[beat_lsb(int'(beat_q), MB) +: MB];
          beat_q        <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_q <= S_RESP;
        end
        S_RD: begin
          mem_address_q <= {addr_q, beat_q};
          rd_vld_q      <= 1'b1;
          rd_idx_q      <= beat_q;
          beat_q        <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_q <= S_DRAIN;
        end
        S_DRAIN: state_q <= S_RESP;
        S_RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  mem_line_buffer #(
    .DW    (MEM_DWIDTH),
    .BEATS (BEATS),
    .BW    (BW)
  ) u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (cap_vld_q),
    .wr_idx_i  (cap_idx_q),
    .wr_data_i (mem_out),
    .line_o    (rsp_rdata)
  );

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_we      = rsp_we_q;
  assign mem_address = mem_address_q;
  assign mem_wren    = mem_wren_q;
  assign mem_data    = mem_data_q;
  assign mem_byteen  = mem_byteen_q;

endmodule

// File: tb/tb_mem_burst_seq.sv
// tb/tb_mem_burst_seq.sv - randomized and directed bench for mem_burst_seq against a line-level model
module tb_mem_burst_seq;

  localparam int MDW = 32, BEATS = 8, LAW = 23, BW = 3, AW = 26, LW = 256, BEW = 32;

  logic            clk = 1'b0;
  logic            reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we, mem_wren;
  logic [LAW-1:0]  req_addr;
  logic [LW-1:0]   req_wdata, rsp_rdata;
  logic [BEW-1:0]  req_byteen;
  logic [AW-1:0]   mem_address;
  logic [MDW-1:0]  mem_data, mem_out;
  logic [3:0]      mem_byteen;

  always #5 clk = ~clk;

  mem_burst_seq #(.MEM_DWIDTH(MDW), .BEATS(BEATS), .LAWIDTH(LAW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .mem_address(mem_address),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_byteen(mem_byteen), .mem_out(mem_out)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return {6'b0, a} ^ 32'hDEAD_BEEF;
  endfunction

  // Memory attached to the DUT: byte-enabled writes, 1-cycle registered reads.
  logic [31:0] env_mem [logic [AW-1:0]];
  logic [31:0] env_w;

  function automatic logic [31:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wren) begin
      env_w = env_rd(mem_address);
      for (int j = 0; j < 4; j++) if (mem_byteen[j]) env_w[8*j +: 8] = mem_data[8*j +: 8];
      env_mem[mem_address] = env_w;
    end else begin
      mem_out <= env_rd(mem_address);
    end
  end

  // Line-level reference: a request occupies the unit from accept until its response handshake.
  logic [31:0]    ref_mem [logic [AW-1:0]];
  logic [31:0]    ref_w;
  logic [AW-1:0]  ref_a;
  bit             started = 0, busy = 0, cur_we;
  int             mdl_n = 0, lat = 0, accepts = 0;
  logic [LAW-1:0] cur_addr;
  logic [LW-1:0]  cur_wdata, exp_line;
  logic [BEW-1:0] cur_be;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy    = 0;
      started = 1;
    end else if (busy) begin
      if (mdl_n >= lat && rsp_ready) busy = 0;
      else mdl_n++;
    end else if (req_valid) begin
      busy = 1; mdl_n = 0; accepts++;
      cur_we = req_we; cur_addr = req_addr; cur_wdata = req_wdata; cur_be = req_byteen;
      lat = req_we ? BEATS + 1 : BEATS + 2;
      for (int b = 0; b < BEATS; b++) begin
        ref_a = {req_addr, BW'(b)};
        ref_w = ref_rd(ref_a);
        if (req_we) begin
          for (int j = 0; j < 4; j++)
            if (req_byteen[b*4+j]) ref_w[8*j +: 8] = req_wdata[b*32 + 8*j +: 8];
          ref_mem[ref_a] = ref_w;
        end else begin
          exp_line[b*32 +: 32] = ref_w;
        end
      end
    end
  end

  // Per-cycle comparison plus a few observations used by the directed checks.
  bit            beat_act, exp_rv;
  int            first_rv = -1, low_touch = 0;
  logic [AW-1:0] first_addr, last_addr;
  logic [LW-1:0] last_rdata;
  logic          rsp_we_seen;

  always @(negedge clk) begin
    if (started) begin
      beat_act = busy && mdl_n >= 1 && mdl_n <= BEATS;
      exp_rv   = busy && mdl_n >= lat;
      chk("req_ready", 256'(req_ready), 256'(!busy));
      chk("mem_wren", 256'(mem_wren), 256'(beat_act && cur_we));
      if (!(beat_act && cur_we)) chk("mem_byteen_idle", 256'(mem_byteen), 256'(0));
      if (beat_act) begin
        chk("mem_address", 256'(mem_address), 256'({cur_addr, BW'(mdl_n - 1)}));
        if (cur_we) begin
          chk("mem_data", 256'(mem_data), 256'(cur_wdata[(mdl_n-1)*32 +: 32]));
          chk("mem_byteen", 256'(mem_byteen), 256'(cur_be[(mdl_n-1)*4 +: 4]));
        end
      end
      chk("rsp_valid", 256'(rsp_valid), 256'(exp_rv));
      if (exp_rv) begin
        chk("rsp_we", 256'(rsp_we), 256'(cur_we));
        if (!cur_we) chk("rsp_rdata", 256'(rsp_rdata), 256'(exp_line));
      end
      if (busy && mdl_n == 0) first_rv = -1;
      if (busy && mdl_n == 1) first_addr = mem_address;
      if (busy && mdl_n == BEATS) last_addr = mem_address;
      if (busy && rsp_valid === 1'b1 && first_rv < 0) begin
        first_rv = mdl_n; last_rdata = rsp_rdata; rsp_we_seen = rsp_we;
      end
      if ((mem_wren || beat_act) && mem_address < AW'(BEATS)) low_touch++;
    end
  end

  task automatic start_txn(input bit we, input logic [LAW-1:0] a, input logic [LW-1:0] wd,
                           input logic [BEW-1:0] be);
    int guard = 0;
    @(posedge clk); #2;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_byteen = be;
    while (!busy && guard < 20) begin @(posedge clk); #2; guard++; end
    req_valid = 0;
    chk("accept_seen", 256'(busy), 256'(1));
  endtask

  task automatic finish_txn(input int delay);
    int guard = 0;
    while (busy && guard < 100) begin
      if (mdl_n >= lat + delay) rsp_ready = 1;
      @(posedge clk); #2; guard++;
    end
    chk("response_done", 256'(busy), 256'(0));
    rsp_ready = 0;
  endtask

  task automatic run_txn(input bit we, input logic [LAW-1:0] a, input logic [LW-1:0] wd,
                         input logic [BEW-1:0] be, input int delay);
    start_txn(we, a, wd, be);
    if (busy) finish_txn(delay);
  endtask

  logic [LW-1:0] line_v, exp_v;
  int guard_m, target;

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_byteen = '0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_we", 256'(rsp_we), 256'(0));
    chk("rst_rsp_rdata", 256'(rsp_rdata), 256'(0));
    chk("rst_mem_wren", 256'(mem_wren), 256'(0));
    chk("rst_mem_address", 256'(mem_address), 256'(0));
    chk("rst_mem_data", 256'(mem_data), 256'(0));
    chk("rst_mem_byteen", 256'(mem_byteen), 256'(0));

    // Full-line write then read-back at line 0x10.
    for (int b = 0; b < BEATS; b++) line_v[b*32 +: 32] = 32'h1000_0000 + b;
    run_txn(1, 23'h10, line_v, '1, 0);
    chk("wr_first_addr", 256'(first_addr), 256'(26'h80));
    chk("wr_last_addr", 256'(last_addr), 256'(26'h87));
    chk("wr_rsp_cycle", 256'(first_rv), 256'(9));
    chk("wr_rsp_we", 256'(rsp_we_seen), 256'(1));
    chk("wr_mem_85", 256'(env_rd(26'h85)), 256'(32'h1000_0005));
    run_txn(0, 23'h10, '0, '0, 0);
    chk("rd_rsp_cycle", 256'(first_rv), 256'(10));
    chk("rd_rsp_we", 256'(rsp_we_seen), 256'(0));
    chk("rd_line", 256'(last_rdata), 256'(line_v));

    // Partial write: only the low byte of beat 2 is enabled.
    line_v = '1;
    line_v[64 +: 32] = 32'hAABB_CCDD;
    run_txn(1, 23'h10, line_v, 32'h0000_0100, 0);
    chk("part_mem_82", 256'(env_rd(26'h82)), 256'(32'h1000_00DD));
    chk("part_mem_83", 256'(env_rd(26'h83)), 256'(32'h1000_0003));

    // Read back under backpressure with a stray request pulse while busy.
    start_txn(0, 23'h10, '0, '0);
    guard_m = 0;
    while (busy && mdl_n < lat && guard_m < 30) begin @(posedge clk); #2; guard_m++; end
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2); req_we = 1; req_addr = 23'h10; req_wdata = '0; req_byteen = '1;
      @(posedge clk); #2;
    end
    req_valid = 0;
    @(negedge clk);
    chk("bp_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("bp_word2", 256'(rsp_rdata[64 +: 32]), 256'(32'h1000_00DD));
    chk("bp_word0", 256'(rsp_rdata[31:0]), 256'(32'h1000_0000));
    finish_txn(0);
    chk("bp_no_write", 256'(env_rd(26'h80)), 256'(32'h1000_0000));

    // Reset in the middle of a read, then a clean read of the same line.
    start_txn(0, 23'h11, '0, '0);
    guard_m = 0;
    while (mdl_n < 3 && guard_m < 20) begin @(posedge clk); #2; guard_m++; end
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_req_ready", 256'(req_ready), 256'(1));
    chk("mid_rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("mid_rst_mem_wren", 256'(mem_wren), 256'(0));
    run_txn(0, 23'h11, '0, '0, 0);
    for (int b = 0; b < BEATS; b++) exp_v[b*32 +: 32] = init_word(26'h88 + AW'(b));
    chk("post_rst_line", 256'(last_rdata), 256'(exp_v));
    chk("post_rst_cycle", 256'(first_rv), 256'(10));

    // Top line: addresses stay in the last 8 words.
    low_touch = 0;
    for (int b = 0; b < BEATS; b++) line_v[b*32 +: 32] = $urandom;
    run_txn(1, '1, line_v, '1, 0);
    chk("top_first_addr", 256'(first_addr), 256'(26'h3FF_FFF8));
    chk("top_last_addr", 256'(last_addr), 256'(26'h3FF_FFFF));
    run_txn(0, '1, '0, '0, 2);
    chk("top_line", 256'(last_rdata), 256'(line_v));
    chk("top_no_low_access", 256'(low_touch), 256'(0));

    // Randomized traffic with random backpressure and requests presented while busy.
    target = accepts + 40;
    guard_m = 0;
    while (accepts < target && guard_m < 6000) begin
      @(posedge clk); #2;
      req_valid = ($urandom % 3 == 0);
      req_we    = $urandom % 2;
      case ($urandom % 4)
        0: req_addr = 23'h10;
        1: req_addr = 23'h11;
        2: req_addr = '1;
        default: req_addr = 23'($urandom);
      endcase
      for (int b = 0; b < BEATS; b++) req_wdata[b*32 +: 32] = $urandom;
      req_byteen = ($urandom % 2) ? '1 : BEW'($urandom);
      rsp_ready  = ($urandom % 4 != 0);
      guard_m++;
    end
    req_valid = 0;
    finish_txn(0);
    chk("rand_accepts", 256'(accepts >= target), 256'(1));
    foreach (ref_mem[k]) chk("final_mem", 256'(env_rd(k)), 256'(ref_mem[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
